counter: RTL and testbench

- 3½-digit BCD event counter for the MC14433 dual-slope ADC model.
- Counts gated clock edges from 0000 to 1999 across three decade stages (units, tens, hundreds) and one half-digit stage (thousands, 0/1).
- Exposes selected digit bits, the full digit buses, an overrange flag and a terminal-count carry.
- Sits between the ADC phase sequencer, which drives the gate and clears, and the output latch/multiplexer.

---
 rtl/counter_pkg.sv | 15 +
 rtl/counter_if.sv | 34 +++
 rtl/counter_bcd_digit.sv | 39 +++
 rtl/counter.sv | 90 +++++++++
 tb/tb_counter.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// Shared types and constants for the MC14433 3-1/2 digit BCD event counter.
package mc14433_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX    = 4'd9;
  localparam int   FULL_SCALE = 1999;

  // Codes 9..15 all behave as the top of the decade; 10..15 are never
  // produced, but if one appears it carries and wraps like a 9.
  function automatic logic bcd_at_top(input bcd_t d);
    return (d >= BCD_MAX);
  endfunction

endpackage

// File: rtl/counter_if.sv
// Control and digit bus between the phase sequencer, the counter and the
// output latch/multiplexer.
interface counter_if;
  import mc14433_pkg::*;

  logic s1;
  logic s2;
  logic s3;
  logic s4;
  logic g2;
  logic qb11;
  logic qb21;
  logic qb31;
  logic qb41;
  logic qb14;
  logic qb24;
  logic qb34;
  logic S2;
  logic G4;
  bcd_t d1;
  bcd_t d2;
  bcd_t d3;

  modport master (
    output s1, s2, s3, s4, g2,
    input  qb11, qb21, qb31, qb41, qb14, qb24, qb34, S2, G4, d1, d2, d3
  );

  modport slave (
    input  s1, s2, s3, s4, g2,
    output qb11, qb21, qb31, qb41, qb14, qb24, qb34, S2, G4, d1, d2, d3
  );

endinterface

// File: rtl/counter_bcd_digit.sv
// One decade stage: counts 0..9 when cin is high, synchronous active-low
// clear that also blocks the carry out of this stage.
module bcd_digit
  import mc14433_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr_n,
  input  logic cin,
  output bcd_t q,
  output logic cout
);

  bcd_t q_q;
  bcd_t q_d;

  // Next digit: clear wins over increment; top-of-decade wraps to 0.
  always_comb begin
    q_d = q_q;
    if (!clr_n) begin
      q_d = '0;
    end else if (cin) begin
      q_d = bcd_at_top(q_q) ? bcd_t'(0) : q_q + bcd_t'(1);
    end
  end

  // Digit register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign cout = cin & bcd_at_top(q_q) & clr_n;

endmodule

// File: rtl/counter.sv
// 3-1/2 digit BCD event counter (0000..1999) with sticky overrange flag
// and combinational terminal-count carry.
module counter
  import mc14433_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  counter_if.slave bus
);

  bcd_t d1_w;
  bcd_t d2_w;
  bcd_t d3_w;
  logic c1_w;
  logic c2_w;
  logic c3_w;
  logic half_q;
  logic half_d;
  logic ovr_q;
  logic ovr_d;

  bcd_digit u_units (
    .clk   (clk),
    .rst   (rst),
    .clr_n (bus.s1),
    .cin   (bus.g2),
    .q     (d1_w),
    .cout  (c1_w)
  );

  bcd_digit u_tens (
    .clk   (clk),
    .rst   (rst),
    .clr_n (bus.s2),
    .cin   (c1_w),
    .q     (d2_w),
    .cout  (c2_w)
  );

  bcd_digit u_hundreds (
    .clk   (clk),
    .rst   (rst),
    .clr_n (bus.s3),
    .cin   (c2_w),
    .q     (d3_w),
    .cout  (c3_w)
  );

  // Half-digit toggles on hundreds carry; a carry while it is 1 is the
  // 1999->0000 wrap and latches overrange. s4 clears both.
  always_comb begin
    half_d = half_q;
    ovr_d  = ovr_q;
    if (!bus.s4) begin
      half_d = 1'b0;
      ovr_d  = 1'b0;
    end else if (c3_w) begin
      half_d = ~half_q;
      if (half_q) begin
        ovr_d = 1'b1;
      end
    end
  end

  // Half-digit and overrange registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      half_q <= half_d;
      ovr_q  <= ovr_d;
    end
  end

  assign bus.d1   = d1_w;
  assign bus.d2   = d2_w;
  assign bus.d3   = d3_w;
  assign bus.qb11 = d1_w[0];
  assign bus.qb21 = d2_w[0];
  assign bus.qb31 = d3_w[0];
  assign bus.qb14 = d1_w[3];
  assign bus.qb24 = d2_w[3];
  assign bus.qb34 = d3_w[3];
  assign bus.qb41 = half_q;
  assign bus.S2   = ovr_q;
  assign bus.G4   = bus.g2 & half_q & (d3_w == BCD_MAX) & (d2_w == BCD_MAX)
                  & (d1_w == BCD_MAX);

endmodule

// File: tb/tb_counter.sv
module tb_counter;
  import mc14433_pkg::*;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   mv;
  bit   ms2;

  counter_if bus ();

  counter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       g2;
    logic [3:0] sn;      // {s4,s3,s2,s1}
    int         reps;
    int         exp_val;
    logic       exp_s2;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int dut_value();
    return int'(bus.qb41) * 1000 + int'(bus.d3) * 100 + int'(bus.d2) * 10 + int'(bus.d1);
  endfunction

  // Reference: value as a plain integer; per-digit arithmetic only when a clear is active.
  task automatic model_step(input logic g2, input logic [3:0] sn);
    int u, t, h, k;
    bit c1, c2, c3;
    if (sn == 4'hF) begin
      if (g2) begin
        if (mv == FULL_SCALE) ms2 = 1'b1;
        mv = (mv + 1) % (FULL_SCALE + 1);
      end
    end else begin
      u = mv % 10; t = (mv / 10) % 10; h = (mv / 100) % 10; k = mv / 1000;
      c1 = g2 && sn[0] && (u == 9);
      u  = !sn[0] ? 0 : (g2 ? (u + 1) % 10 : u);
      c2 = c1 && sn[1] && (t == 9);
      t  = !sn[1] ? 0 : (c1 ? (t + 1) % 10 : t);
      c3 = c2 && sn[2] && (h == 9);
      h  = !sn[2] ? 0 : (c2 ? (h + 1) % 10 : h);
      if (!sn[3]) begin
        k = 0; ms2 = 1'b0;
      end else if (c3) begin
        if (k == 1) ms2 = 1'b1;
        k = 1 - k;
      end
      mv = k * 1000 + h * 100 + t * 10 + u;
    end
  endtask

  task automatic check_state();
    int u, t, h;
    u = mv % 10; t = (mv / 10) % 10; h = (mv / 100) % 10;
    chk("value", dut_value(), mv);
    chk("S2", int'(bus.S2), int'(ms2));
    chk("qb41", int'(bus.qb41), mv / 1000);
    chk("qb11", int'(bus.qb11), u % 2);
    chk("qb21", int'(bus.qb21), t % 2);
    chk("qb31", int'(bus.qb31), h % 2);
    chk("qb14", int'(bus.qb14), (u >= 8) ? 1 : 0);
    chk("qb24", int'(bus.qb24), (t >= 8) ? 1 : 0);
    chk("qb34", int'(bus.qb34), (h >= 8) ? 1 : 0);
  endtask

  task automatic step(input logic g2, input logic [3:0] sn);
    bus.g2 = g2;
    {bus.s4, bus.s3, bus.s2, bus.s1} = sn;
    #1;
    chk("G4_pre", int'(bus.G4), (g2 && mv == FULL_SCALE) ? 1 : 0);
    @(posedge clk);
    model_step(g2, sn);
    #1;
    check_state();
  endtask

  // Asserted between edges so the zeroing must be asynchronous.
  task automatic do_reset();
    bus.g2 = 1'b1;
    {bus.s4, bus.s3, bus.s2, bus.s1} = 4'hF;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    mv = 0; ms2 = 1'b0;
    chk("rst_value", dut_value(), 0);
    chk("rst_S2", int'(bus.S2), 0);
    chk("rst_G4", int'(bus.G4), 0);
    chk("rst_qb14", int'(bus.qb14), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.g2 = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; mv = 0; ms2 = 1'b0;
    rst = 1'b0;
    bus.g2 = 1'b0;
    {bus.s4, bus.s3, bus.s2, bus.s1} = 4'hF;

    tbl[0]  = '{1'b1, 4'hF,    10,   10, 1'b0};
    tbl[1]  = '{1'b0, 4'hF,     5,   10, 1'b0};
    tbl[2]  = '{1'b1, 4'hF,   113,  123, 1'b0};
    tbl[3]  = '{1'b1, 4'b1110,  1,  120, 1'b0};
    tbl[4]  = '{1'b1, 4'hF,     9,  129, 1'b0};
    tbl[5]  = '{1'b1, 4'b1101,  1,  100, 1'b0};
    tbl[6]  = '{1'b1, 4'hF,  1899, 1999, 1'b0};
    tbl[7]  = '{1'b1, 4'hF,     1,    0, 1'b1};
    tbl[8]  = '{1'b1, 4'hF,     5,    5, 1'b1};
    tbl[9]  = '{1'b1, 4'b0111,  1,    6, 1'b0};
    tbl[10] = '{1'b1, 4'h0,     1,    0, 1'b0};

    // Table-driven run from reset.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      for (int r = 0; r < tbl[i].reps; r++) step(tbl[i].g2, tbl[i].sn);
      chk($sformatf("tbl%0d_value", i), dut_value(), tbl[i].exp_val);
      chk($sformatf("tbl%0d_S2", i), int'(bus.S2), int'(tbl[i].exp_s2));
    end

    // 10 gated clocks from zero.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 4'hF);
    chk("ten_d1", int'(bus.d1), 0);
    chk("ten_d2", int'(bus.d2), 1);
    chk("ten_qb21", int'(bus.qb21), 1);
    chk("ten_qb11", int'(bus.qb11), 0);

    // Full scale and wrap.
    do_reset();
    for (int i = 0; i < 1998; i++) step(1'b1, 4'hF);
    chk("pre_value", dut_value(), 1998);
    step(1'b1, 4'hF);
    #1;
    chk("fs_G4", int'(bus.G4), 1);
    chk("fs_qb41", int'(bus.qb41), 1);
    chk("fs_qb34", int'(bus.qb34), 1);
    chk("fs_qb14", int'(bus.qb14), 1);
    step(1'b1, 4'hF);
    #1;
    chk("wrap_value", dut_value(), 0);
    chk("wrap_S2", int'(bus.S2), 1);
    chk("wrap_G4", int'(bus.G4), 0);
    step(1'b1, 4'hF);
    step(1'b1, 4'hF);
    step(1'b1, 4'b0111);
    chk("s4clr_S2", int'(bus.S2), 0);
    chk("s4clr_value", dut_value(), 3);

    // Gate toggling every clock.
    do_reset();
    for (int i = 0; i < 20; i++) step((i % 2 == 0) ? 1'b1 : 1'b0, 4'hF);
    chk("toggle_value", dut_value(), 10);

    // Mid-count asynchronous reset.
    for (int i = 0; i < 37; i++) step(1'b1, 4'hF);
    do_reset();

    // Randomized stimulus against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic       g;
      logic [3:0] sn;
      g = ($urandom_range(0, 3) != 0);
      for (int b = 0; b < 4; b++) sn[b] = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 799) == 0) do_reset();
      step(g, sn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
